debug_register_dump: RTL and testbench
======================================

# debug_register_dump

Debug-unit-side reader for the register file's debug read port. On command it walks every general-purpose register address, captures each word returned on the debug data port, and streams it as bytes (MSB first) over a valid/ready byte interface toward the UART transmitter. It sits between the register file and the debug unit's TX path, and is used when the debug unit dumps processor state after a halt or step.

## Interface

Parameters:
- CANTIDAD_REGISTROS, 32: number of registers to dump, addresses 0 to CANTIDAD_REGISTROS-1.
- CANTIDAD_BITS_REGISTROS, 32: register width. Must be a multiple of 8.
- CANTIDAD_BITS_ADDRESS_REGISTROS, 5: register address width.
- LATENCIA_LECTURA, 1: number of clock edges between the register file sampling an address and its data being valid. Must be ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - i_clock  in  1  system clock; all state changes on the rising edge.
  - i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  begins a dump; sampled only in IDLE.
- i_abort  in  1  synchronous cancel; returns to IDLE without o_done.
- o_reg_read_address  out  CANTIDAD_BITS_ADDRESS_REGISTROS  drives the register file debug read address.
- i_reg_data  in  CANTIDAD_BITS_REGISTROS  debug read data from the register file.
- o_byte_data  out  8  byte toward the TX path.
- o_byte_valid  out  1  o_byte_data is valid.
- i_byte_ready  in  1  the TX path accepts the byte.
- o_busy  out  1  high from the accepted start until completion or abort.
- o_done  out  1  one-cycle pulse after the last byte of the last register.

## Operation

- Bytes per register: NB = CANTIDAD_BITS_REGISTROS/8.
- State machine: IDLE, WAIT_DATA, SEND.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - o_reg_read_address=0, o_byte_data=0, o_byte_valid=0, o_busy=0, o_done=0.
  - Latency counter, byte index and shift register clear to 0.
- IDLE: when i_start=1 (and i_abort=0) at an edge:
  - o_reg_read_address<=0, o_busy<=1.
  - Latency counter loads LATENCIA_LECTURA.
  - Go to WAIT_DATA.
- WAIT_DATA:
  - Decrement the counter each edge.
  - At the edge where the counter reaches 0: capture i_reg_data into the shift register, o_byte_data<=i_reg_data[MSB byte], o_byte_valid<=1, byte index<=0.
  - Go to SEND.
- SEND: a transfer occurs at each edge where o_byte_valid&i_byte_ready.
  - On a transfer with byte index < NB-1: present the next lower byte and increment the index. o_byte_valid stays 1.
  - On a transfer of the last byte (index NB-1):
    - o_byte_valid<=0.
    - If the address is CANTIDAD_REGISTROS-1: o_busy<=0, o_done<=1, go to IDLE.
    - Otherwise: address+1, reload the counter, go to WAIT_DATA.
- o_done is high for exactly one cycle and cleared at the next edge.
- i_start while busy: ignored.
- i_abort in any non-IDLE state:
  - Next edge: IDLE, o_byte_valid=0, o_busy=0, o_done=0, address=0.
  - Abort wins over a simultaneous transfer; that byte is treated as not sent.
- Address wrap never occurs: the last address ends the dump.

## Timing

- Captured data corresponds to the address driven LATENCIA_LECTURA+1 edges earlier. This matches the register file, which latches the debug data on the rising edge after the address changes.
- o_reg_read_address is stable from WAIT_DATA entry until the last byte of that register is accepted.
- While o_byte_valid=1 and i_byte_ready=0, o_byte_data and o_byte_valid hold unchanged. There is no combinational path from i_byte_ready to any output.
- Cycle counts with i_byte_ready held at 1 and start accepted at edge E0:
  - Register r is captured at edge E(r·(L+1+NB)+L+1), with L=LATENCIA_LECTURA.
  - Its last byte is accepted at edge E((r+1)·(L+1+NB)).
  - Defaults: 6 cycles per register; o_done asserts after edge E192.
- Minimum gap from o_done to the next accepted i_start: 1 cycle, since IDLE samples i_start on the edge after completion.

## Test plan

- **Basic dump.** Register model holds reg[k]=0x01000000·k+k, i_byte_ready=1, pulse i_start.
  - Response: 128 bytes; register 5 gives 05,00,00,05; o_done one cycle after edge E192; o_busy high for 192 cycles.
- **Backpressure.** i_byte_ready toggles 1 cycle on, 2 cycles off.
  - Response: byte stream identical to the basic dump; o_byte_data stable while stalled; address never changes mid-register.
- **Latency parameter.** Set LATENCIA_LECTURA=3 with the model delaying data by 3 edges.
  - Response: correct data; 8 cycles per register; o_done after edge E256.
- **Start while busy.** Pulse i_start at byte 40.
  - Response: ignored; exactly 128 bytes and a single o_done pulse.
- **Abort.** Assert i_abort on the same edge as a transfer of register 7, byte 2.
  - Response: next cycle IDLE, o_busy=0, o_byte_valid=0, no o_done. A new i_start restarts at address 0.
- **Async reset mid-SEND.** Raise i_reset between clock edges.
  - Response: all outputs 0 immediately, without waiting for an edge; the FSM stays in IDLE after reset is released.

Source files
------------

// File: rtl/debug_register_dump_if.sv
// Handshake bundle between the register dump engine, the register file debug
// read port and the byte-wide TX path.
interface debug_register_dump_if #(
    parameter int CANTIDAD_BITS_REGISTROS         = 32,
    parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = 5
);
    logic                                       i_start;
    logic                                       i_abort;
    logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] o_reg_read_address;
    logic [CANTIDAD_BITS_REGISTROS-1:0]         i_reg_data;
    logic [7:0]                                 o_byte_data;
    logic                                       o_byte_valid;
    logic                                       i_byte_ready;
    logic                                       o_busy;
    logic                                       o_done;

    modport slave (
        input  i_start, i_abort, i_reg_data, i_byte_ready,
        output o_reg_read_address, o_byte_data, o_byte_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_abort, i_reg_data, i_byte_ready,
        input  o_reg_read_address, o_byte_data, o_byte_valid, o_busy, o_done
    );
endinterface

// File: rtl/debug_register_dump.sv
// Walks every register address on the debug read port and streams each word
// MSB-first as bytes over a valid/ready interface toward the UART transmitter.
//
// state       | meaning
// S_IDLE      | waiting for i_start, outputs quiet
// S_WAIT_DATA | address driven, counting down register file read latency
// S_SEND      | word captured, presenting bytes until the last one is taken
module debug_register_dump #(
    parameter int CANTIDAD_REGISTROS              = 32,
    parameter int CANTIDAD_BITS_REGISTROS         = 32,
    parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = 5,
    parameter int LATENCIA_LECTURA                = 1
) (
    input logic                  i_clock,
    input logic                  i_reset,
    debug_register_dump_if.slave bus
);
    localparam int NB   = CANTIDAD_BITS_REGISTROS / 8;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNTW = $clog2(LATENCIA_LECTURA + 1);
    localparam int W    = CANTIDAD_BITS_REGISTROS;
    localparam int AW   = CANTIDAD_BITS_ADDRESS_REGISTROS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_SEND
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    shifted;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = shift_q << 8;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = CNTW'(LATENCIA_LECTURA);
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = bus.i_reg_data;
                    byte_d  = bus.i_reg_data[W-1 -: 8];
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_SEND: begin
                if (valid_q && bus.i_byte_ready) begin
                    if (idx_q != IDXW'(NB - 1)) begin
                        shift_d = shifted;
                        byte_d  = shifted[W-1 -: 8];
                        idx_d   = idx_q + IDXW'(1);
                    end else begin
                        valid_d = 1'b0;
                        if (addr_q == AW'(CANTIDAD_REGISTROS - 1)) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            cnt_d   = CNTW'(LATENCIA_LECTURA);
                            state_d = S_WAIT_DATA;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over a simultaneous byte transfer or completion.
        if (bus.i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            addr_d  = '0;
        end
    end

    assign bus.o_reg_read_address = addr_q;
    assign bus.o_byte_data        = byte_q;
    assign bus.o_byte_valid       = valid_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_done             = done_q;
endmodule

// File: tb/tb_debug_register_dump.sv
// Scoreboard bench for debug_register_dump: two instances (read latency 1 and 3),
// each fed by a register file model holding reg[k] = 0x01000000*k + k.
module tb_debug_register_dump;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    debug_register_dump_if u_if ();
    debug_register_dump_if u_if3 ();

    debug_register_dump #(.LATENCIA_LECTURA(1)) dut1 (.i_clock(clk), .i_reset(rst), .bus(u_if.slave));
    debug_register_dump #(.LATENCIA_LECTURA(3)) dut3 (.i_clock(clk), .i_reset(rst), .bus(u_if3.slave));

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp3_q[$];

    function automatic logic [31:0] reg_val(input logic [4:0] k);
        return 32'h0100_0000 * 32'(k) + 32'(k);
    endfunction

    // Hand-derived byte b (MSB first) of reg[k]: k, 00, 00, k.
    function automatic logic [7:0] exp_byte(input int k, input int b);
        return (b == 0 || b == 3) ? 8'(k) : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file models: latency L means L pipeline stages after the address.
    logic [31:0] p1, p3a, p3b, p3c;
    always @(posedge clk) begin
        p1  <= reg_val(u_if.o_reg_read_address);
        p3a <= reg_val(u_if3.o_reg_read_address);
        p3b <= p3a;
        p3c <= p3b;
    end
    assign u_if.i_reg_data  = p1;
    assign u_if3.i_reg_data = p3c;

    // Ready driver: fixed level or 1-on/2-off backpressure pattern.
    bit   bp_en = 1'b0;
    logic ready_fix = 1'b1;
    int   bp_ph = 0;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            u_if.i_byte_ready = (bp_ph == 0);
            bp_ph = (bp_ph == 2) ? 0 : bp_ph + 1;
        end else begin
            u_if.i_byte_ready = ready_fix;
        end
    end

    // Monitor for the latency-1 instance.
    int         byte_cnt = 0;
    int         base = 0;
    int         busy_cycles = 0;
    int         done_cnt = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (u_if.o_busy) busy_cycles++;
            if (u_if.o_done) done_cnt++;
            if (u_if.o_byte_valid)
                check("addr_stable", 32'(u_if.o_reg_read_address), 32'((byte_cnt - base) / 4));
            if (stall_prev) begin
                check("stall_valid", 32'(u_if.o_byte_valid), 32'd1);
                check("stall_data", 32'(u_if.o_byte_data), 32'(stall_data));
            end
            if (u_if.o_byte_valid && u_if.i_byte_ready && !u_if.i_abort) begin
                if (exp_q.size() == 0) check("unexpected_byte", 32'(u_if.o_byte_data), 32'hFFFF_FFFF);
                else check("byte", 32'(u_if.o_byte_data), 32'(exp_q.pop_front()));
                byte_cnt++;
            end
            stall_prev = u_if.o_byte_valid && !u_if.i_byte_ready;
            stall_data = u_if.o_byte_data;
        end
    end

    // Monitor for the latency-3 instance.
    int busy3 = 0;
    int done3 = 0;
    int bytes3 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if3.o_busy) busy3++;
            if (u_if3.o_done) done3++;
            if (u_if3.o_byte_valid && u_if3.i_byte_ready) begin
                if (exp3_q.size() == 0) check("lat3_unexpected_byte", 32'(u_if3.o_byte_data), 32'hFFFF_FFFF);
                else check("lat3_byte", 32'(u_if3.o_byte_data), 32'(exp3_q.pop_front()));
                bytes3++;
            end
        end
    end

    task automatic push_dump(input int nbytes);
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 4; b++)
                if (k * 4 + b < nbytes) exp_q.push_back(exp_byte(k, b));
    endtask

    task automatic pulse_start();
        u_if.i_start = 1'b1;
        @(posedge clk); #1;
        u_if.i_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string name);
        int t = 0;
        while ((byte_cnt - base) < n && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if ((byte_cnt - base) < n) check(name, 32'(byte_cnt - base), 32'(n));
    endtask

    task automatic wait_done(input int d0, input string name);
        int t = 0;
        while (done_cnt == d0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == d0) check(name, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic full_run(input string tag, input int exp_busy);
        int d0, b0;
        push_dump(128);
        base = byte_cnt;
        d0 = done_cnt;
        b0 = busy_cycles;
        pulse_start();
        wait_done(d0, {tag, "_done_timeout"});
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_byte_count"}, 32'(byte_cnt - base), 32'd128);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (exp_busy > 0) check({tag, "_busy_cycles"}, 32'(busy_cycles - b0), 32'(exp_busy));
        check({tag, "_idle_busy"}, 32'(u_if.o_busy), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_addr"}, 32'(u_if.o_reg_read_address), 32'd0);
        check({tag, "_data"}, 32'(u_if.o_byte_data), 32'd0);
        check({tag, "_valid"}, 32'(u_if.o_byte_valid), 32'd0);
        check({tag, "_busy"}, 32'(u_if.o_busy), 32'd0);
        check({tag, "_done"}, 32'(u_if.o_done), 32'd0);
    endtask

    initial begin
        int d0, t;
        u_if.i_start  = 1'b0;
        u_if.i_abort  = 1'b0;
        u_if3.i_start = 1'b0;
        u_if3.i_abort = 1'b0;
        u_if3.i_byte_ready = 1'b1;

        #2 rst = 1'b1;
        #1 check_quiet("reset");
        check("lat3_reset_busy", 32'(u_if3.o_busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_quiet("post_reset");

        // Basic dump: 6 cycles per register, done right after edge E192.
        full_run("basic", 192);

        // Backpressure: same stream, stall checks in the monitor.
        bp_en = 1'b1;
        full_run("bp", 0);
        bp_en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Start while busy is ignored.
        push_dump(128);
        base = byte_cnt;
        d0 = done_cnt;
        t = busy_cycles;
        pulse_start();
        wait_bytes(40, "swb_reach40_timeout");
        pulse_start();
        wait_done(d0, "swb_done_timeout");
        repeat (3) begin @(posedge clk); #1; end
        check("swb_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("swb_byte_count", 32'(byte_cnt - base), 32'd128);
        check("swb_busy_cycles", 32'(busy_cycles - t), 32'd192);

        // Abort on the edge that would transfer register 7 byte 2 (stream byte 30).
        push_dump(30);
        base = byte_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_bytes(30, "abort_reach30_timeout");
        check("abort_presented_valid", 32'(u_if.o_byte_valid), 32'd1);
        check("abort_presented_addr", 32'(u_if.o_reg_read_address), 32'd7);
        u_if.i_abort = 1'b1;
        @(posedge clk); #1;
        u_if.i_abort = 1'b0;
        check("abort_busy", 32'(u_if.o_busy), 32'd0);
        check("abort_valid", 32'(u_if.o_byte_valid), 32'd0);
        check("abort_done", 32'(u_if.o_done), 32'd0);
        check("abort_addr", 32'(u_if.o_reg_read_address), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_bytes_sent", 32'(byte_cnt - base), 32'd30);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        full_run("restart", 192);

        // Asynchronous reset between edges in the middle of a dump.
        push_dump(128);
        base = byte_cnt;
        pulse_start();
        wait_bytes(10, "rst_reach10_timeout");
        check("rst_pre_valid", 32'(u_if.o_byte_valid), 32'd1);
        #3 rst = 1'b1;
        #1 check_quiet("async_rst");
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check_quiet("after_rst");

        // Latency 3: 8 cycles per register, done right after edge E256.
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 4; b++) exp3_q.push_back(exp_byte(k, b));
        busy3 = 0;
        done3 = 0;
        u_if3.i_start = 1'b1;
        @(posedge clk); #1;
        u_if3.i_start = 1'b0;
        t = 0;
        while (done3 == 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("lat3_done_pulses", 32'(done3), 32'd1);
        check("lat3_busy_cycles", 32'(busy3), 32'd256);
        check("lat3_byte_count", 32'(bytes3), 32'd128);
        check("lat3_queue_empty", 32'(exp3_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
